// File: rtl/adc_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_pkg
// Brief    : Shared types and defaults for the ADC capture sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package adc_capture_pkg;

    localparam int DEF_NCH   = 3;
    localparam int DEF_DW    = 32;
    localparam int DEF_AW    = 10;
    localparam int DEF_NBANK = 2;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/adc_capture_seq_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Round-robin arbiter; search begins one past the last grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NCH = 3,
    parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] i_req,
    input  logic [CHW-1:0] i_last,
    output logic [NCH-1:0] o_gnt,
    output logic [CHW-1:0] o_idx,
    output logic           o_valid
);

    int w_k;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_k     = 0;
        for (int i = 1; i <= NCH; i++) begin
            w_k = (int'(i_last) + i) % NCH;
            if (!o_valid && i_req[w_k]) begin
                o_valid    = 1'b1;
                o_gnt[w_k] = 1'b1;
                o_idx      = CHW'(w_k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_capture_seq.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture_seq
// Brief    : Multi-channel capture sequencer writing decimator samples to SRAM banks.
// Revision : 1.0 - initial release
// ============================================================================
module adc_capture_seq
    import adc_capture_pkg::*;
#(
    parameter int NCH   = DEF_NCH,
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int NBANK = DEF_NBANK,
    parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic [NCH*DW-1:0] ch_data_i,
    input  logic [NCH-1:0]    ch_valid_i,
    input  logic [NCH-1:0]    ch_en_i,
    input  logic              mode_i,
    input  logic [CHW-1:0]    sel_i,
    input  logic              ring_i,
    input  logic [AW:0]       count_i,
    input  logic              tag_en_i,
    input  logic              start_i,
    input  logic              abort_i,
    output logic [NBANK-1:0]  mem_csb_o,
    output logic [NBANK-1:0]  mem_web_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [DW-1:0]     mem_din_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [BW-1:0]     bank_o,
    output logic [AW:0]       wr_count_o,
    output logic [NCH-1:0]    ovr_o
);

    state_t           r_state, w_state_nxt;
    logic             r_mode, r_ring, r_tag, r_done;
    logic [CHW-1:0]   r_sel, r_last;
    logic [AW:0]      r_lim, r_wr_count;
    logic [BW-1:0]    r_bank;
    logic [DW-1:0]    r_hold [NCH];
    logic [NCH-1:0]   r_full, r_ovr;
    logic [NBANK-1:0] r_csb, r_web;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_din;

    logic [NCH-1:0]   w_req, w_gnt, w_load;
    logic [CHW-1:0]   w_gidx;
    logic             w_gvalid, w_wr, w_last, w_busy;
    logic [AW:0]      w_cnt_nxt;
    logic [DW-1:0]    w_gdata, w_din;

    rr_arbiter #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_arb (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_gnt   (w_gnt),
        .o_idx   (w_gidx),
        .o_valid (w_gvalid)
    );

    always_comb begin
        w_req = r_full;
        if (r_mode == MODE_SINGLE) begin
            w_req = r_full & (NCH'(1) << r_sel);
        end
        w_gdata = '0;
        for (int c = 0; c < NCH; c++) begin
            w_gdata = w_gdata | (r_hold[c] & {DW{w_gnt[c]}});
            w_load[c] = ch_valid_i[c] && ch_en_i[c] && (r_state == ST_RUN) && !abort_i
                        && ((r_mode == MODE_SCAN) || (r_sel == CHW'(c)));
        end
    end

    // Tagging overwrites the top CHW bits with the source channel index.
    assign w_din     = r_tag ? {w_gidx, w_gdata[DW-CHW-1:0]} : w_gdata;
    assign w_wr      = (r_state == ST_RUN) && w_gvalid && !abort_i;
    assign w_cnt_nxt = r_wr_count + (AW+1)'(1);
    assign w_last    = w_cnt_nxt[AW] || ((r_lim != '0) && (w_cnt_nxt == r_lim));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start_i && !abort_i) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (abort_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_wr && w_last && !r_ring) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != ST_IDLE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_mode     <= MODE_SINGLE;
            r_sel      <= '0;
            r_ring     <= 1'b0;
            r_lim      <= '0;
            r_tag      <= 1'b0;
            r_full     <= '0;
            r_ovr      <= '0;
            r_last     <= CHW'(NCH-1);
            r_wr_count <= '0;
            r_bank     <= '0;
            r_csb      <= '1;
            r_web      <= '1;
            r_addr     <= '0;
            r_din      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_csb  <= '1;
            r_web  <= '1;
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (start_i && !abort_i) begin
                    r_mode     <= mode_i;
                    r_sel      <= sel_i;
                    r_ring     <= ring_i;
                    r_lim      <= count_i;
                    r_tag      <= tag_en_i;
                    r_full     <= '0;
                    r_ovr      <= '0;
                    r_last     <= CHW'(NCH-1);
                    r_wr_count <= '0;
                    r_bank     <= '0;
                    r_addr     <= '0;
                end
            end else if (abort_i || (r_state == ST_DONE)) begin
                r_full <= '0;
            end else begin
                if (w_wr) begin
                    for (int b = 0; b < NBANK; b++) begin
                        if (r_bank == BW'(b)) begin
                            r_csb[b] <= 1'b0;
                            r_web[b] <= 1'b0;
                        end
                    end
                    r_addr <= r_wr_count[AW-1:0];
                    r_din  <= w_din;
                    r_last <= w_gidx;
                    if (w_last) begin
                        r_wr_count <= '0;
                        r_done     <= 1'b1;
                        if (r_ring) begin
                            r_bank <= (r_bank == BW'(NBANK-1)) ? '0 : r_bank + BW'(1);
                        end
                    end else begin
                        r_wr_count <= w_cnt_nxt;
                    end
                end
                // A drain in the same cycle as a reload is not an overrun.
                for (int c = 0; c < NCH; c++) begin
                    if (w_load[c]) begin
                        r_full[c] <= 1'b1;
                        if (r_full[c] && !(w_wr && w_gnt[c])) begin
                            r_ovr[c] <= 1'b1;
                        end
                    end else if (w_wr && w_gnt[c]) begin
                        r_full[c] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        for (int c = 0; c < NCH; c++) begin
            if (w_load[c]) begin
                r_hold[c] <= ch_data_i[c*DW +: DW];
            end
        end
    end

    assign mem_csb_o  = r_csb;
    assign mem_web_o  = r_web;
    assign mem_addr_o = r_addr;
    assign mem_din_o  = r_din;
    assign busy_o     = w_busy;
    assign done_o     = r_done;
    assign bank_o     = r_bank;
    assign wr_count_o = r_wr_count;
    assign ovr_o      = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_capture_seq
// Brief    : Self-checking bench for adc_capture_seq against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_capture_seq;

    localparam int NCH = 3, DW = 32, AW = 3, NBANK = 2, CHW = 2, BW = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [NCH*DW-1:0] ch_data = '0;
    logic [NCH-1:0]    ch_valid = '0, ch_en = '1;
    logic              mode = 1'b0, ring = 1'b0, tag_en = 1'b0, start = 1'b0, abort = 1'b0;
    logic [CHW-1:0]    sel = '0;
    logic [AW:0]       count = '0;

    logic [NBANK-1:0]  mem_csb_o, mem_web_o;
    logic [AW-1:0]     mem_addr_o;
    logic [DW-1:0]     mem_din_o;
    logic              busy_o, done_o;
    logic [BW-1:0]     bank_o;
    logic [AW:0]       wr_count_o;
    logic [NCH-1:0]    ovr_o;

    always #5 clk = ~clk;

    adc_capture_seq #(.NCH(NCH), .DW(DW), .AW(AW), .NBANK(NBANK)) dut (
        .wb_clk_i (clk),       .wb_rst_ni (rst_n),
        .ch_data_i (ch_data),  .ch_valid_i (ch_valid), .ch_en_i (ch_en),
        .mode_i (mode),        .sel_i (sel),           .ring_i (ring),
        .count_i (count),      .tag_en_i (tag_en),     .start_i (start),
        .abort_i (abort),      .mem_csb_o (mem_csb_o), .mem_web_o (mem_web_o),
        .mem_addr_o (mem_addr_o), .mem_din_o (mem_din_o), .busy_o (busy_o),
        .done_o (done_o),      .bank_o (bank_o),       .wr_count_o (wr_count_o),
        .ovr_o (ovr_o)
    );

    int n_checks = 0, n_fail = 0, n_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: 0 = idle, 1 = capturing, 2 = finished (one cycle).
    int               m_st, m_last, m_cnt, m_bank, c_sel, c_count;
    bit               c_mode, c_ring, c_tag;
    bit               m_full [NCH];
    logic [DW-1:0]    m_hold [NCH];
    logic [NBANK-1:0] e_csb, e_web;
    logic [AW-1:0]    e_addr;
    logic [DW-1:0]    e_din;
    logic [NCH-1:0]   e_ovr;
    bit               e_done;

    task automatic model_reset();
        m_st = 0; m_last = NCH-1; m_cnt = 0; m_bank = 0;
        for (int c = 0; c < NCH; c++) m_full[c] = 0;
        e_csb = '1; e_web = '1; e_addr = '0; e_din = '0; e_ovr = '0; e_done = 0;
    endtask

    task automatic model_step();
        int g, lim;
        e_csb = '1; e_web = '1; e_done = 0;
        if (m_st == 0) begin
            if (start && !abort) begin
                c_mode = mode; c_sel = int'(sel); c_ring = ring; c_count = int'(count); c_tag = tag_en;
                m_cnt = 0; m_bank = 0; m_last = NCH-1; e_addr = '0; e_ovr = '0;
                for (int c = 0; c < NCH; c++) m_full[c] = 0;
                m_st = 1;
            end
        end else if (abort || m_st == 2) begin
            for (int c = 0; c < NCH; c++) m_full[c] = 0;
            m_st = 0;
        end else begin
            g = -1;
            for (int i = 1; i <= NCH; i++) begin
                int k;
                k = (m_last + i) % NCH;
                if (g < 0 && m_full[k] && (c_mode || k == c_sel)) g = k;
            end
            if (g >= 0) begin
                e_csb[m_bank] = 1'b0;
                e_web[m_bank] = 1'b0;
                e_addr = AW'(m_cnt);
                e_din = c_tag ? {CHW'(g), m_hold[g][DW-CHW-1:0]} : m_hold[g];
                m_full[g] = 0;
                m_last = g;
                m_cnt++;
                lim = (c_count == 0) ? (1 << AW) : c_count;
                if (m_cnt >= lim || m_cnt == (1 << AW)) begin
                    e_done = 1; m_cnt = 0;
                    if (c_ring) m_bank = (m_bank + 1) % NBANK;
                    else m_st = 2;
                end
            end
            for (int c = 0; c < NCH; c++) begin
                if (ch_valid[c] && ch_en[c] && (c_mode || c == c_sel)) begin
                    if (m_full[c]) e_ovr[c] = 1'b1;
                    m_hold[c] = ch_data[c*DW +: DW];
                    m_full[c] = 1;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    typedef struct { int bank; int addr; logic [DW-1:0] din; } wr_t;
    wr_t log_q[$];

    always @(posedge clk) begin
        #1;
        check("csb", mem_csb_o, e_csb);
        check("web", mem_web_o, e_web);
        check("addr", mem_addr_o, e_addr);
        if (e_csb != '1) check("din", mem_din_o, e_din);
        check("done", done_o, e_done);
        check("busy", busy_o, m_st != 0);
        check("bank", bank_o, m_bank);
        check("wr_count", wr_count_o, m_cnt);
        check("ovr", ovr_o, e_ovr);
        if (mem_csb_o != '1) begin
            wr_t w;
            w.bank = -1;
            for (int b = 0; b < NBANK; b++) if (!mem_csb_o[b]) w.bank = b;
            w.addr = int'(mem_addr_o);
            w.din  = mem_din_o;
            log_q.push_back(w);
        end
        if (done_o) n_done++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_run(input bit md, input int s, input bit rg, input int cnt, input bit tg);
        @(negedge clk);
        mode = md; sel = CHW'(s); ring = rg; count = (AW+1)'(cnt); tag_en = tg; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        log_q.delete();
        n_done = 0;
    endtask

    task automatic pulse(input logic [NCH-1:0] v, input logic [DW-1:0] d0, d1, d2);
        ch_valid = v; ch_data = {d2, d1, d0};
        @(negedge clk);
        ch_valid = '0;
    endtask

    function automatic int log_addr(input int i);
        return (log_q.size() > i) ? log_q[i].addr : -1;
    endfunction
    function automatic int log_bank(input int i);
        return (log_q.size() > i) ? log_q[i].bank : -1;
    endfunction
    function automatic logic [DW-1:0] log_din(input int i);
        return (log_q.size() > i) ? log_q[i].din : '1;
    endfunction

    initial begin
        #1 rst_n = 1'b0;
        cyc(2);
        check("rst_csb", mem_csb_o, 2'b11);
        check("rst_web", mem_web_o, 2'b11);
        check("rst_busy", busy_o, 0);
        check("rst_ovr", ovr_o, 0);
        rst_n = 1'b1;
        cyc(2);

        // Single mode on ch1; ch0/ch2 traffic must be ignored.
        begin_run(0, 1, 0, 4, 0);
        pulse(3'b010, 0, 32'hA0, 0);
        pulse(3'b101, 32'h55, 0, 32'h66);
        pulse(3'b010, 0, 32'hA1, 0);
        pulse(3'b010, 0, 32'hA2, 0);
        pulse(3'b111, 32'h1, 32'hA3, 32'h2);
        cyc(5);
        check("single_nwr", log_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("single_addr", log_addr(i), i);
            check("single_bank", log_bank(i), 0);
            check("single_din", log_din(i), 32'hA0 + i);
        end
        check("single_done", n_done, 1);
        check("single_busy", busy_o, 0);

        // Scan with tagging; grant order 0,1,2.
        begin_run(1, 0, 0, 3, 1);
        pulse(3'b111, 32'h11, 32'h11, 32'h11);
        cyc(6);
        check("tag_nwr", log_q.size(), 3);
        check("tag_din0", log_din(0), 32'h0000_0011);
        check("tag_din1", log_din(1), 32'h4000_0011);
        check("tag_din2", log_din(2), 32'h8000_0011);
        check("tag_done", n_done, 1);

        // Overrun on ch0 while ch1/ch2 are drained first.
        begin_run(1, 0, 0, 0, 0);
        pulse(3'b110, 0, 32'hB1, 32'hB2);
        pulse(3'b001, 32'hC1, 0, 0);
        pulse(3'b001, 32'hC2, 0, 0);
        cyc(4);
        check("ovr_flag", ovr_o, 3'b001);
        check("ovr_nwr", log_q.size(), 3);
        check("ovr_din0", log_din(0), 32'hB1);
        check("ovr_din1", log_din(1), 32'hB2);
        check("ovr_din2", log_din(2), 32'hC2);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_nodone", n_done, 0);

        // Ring mode, two samples per bank.
        begin_run(0, 0, 1, 2, 0);
        check("start_clr_ovr", ovr_o, 0);
        for (int i = 0; i < 6; i++) pulse(3'b001, 32'hD0 + i, 0, 0);
        cyc(3);
        check("ring_nwr", log_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check("ring_bank", log_bank(i), (i / 2) % 2);
            check("ring_addr", log_addr(i), i % 2);
        end
        check("ring_done", n_done, 3);
        check("ring_busy", busy_o, 1);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        check("ring_abort_busy", busy_o, 0);

        // count = 0 means a full 2^AW bank.
        begin_run(0, 2, 0, 0, 0);
        for (int i = 0; i < 8; i++) pulse(3'b100, 0, 0, 32'hE0 + i);
        cyc(4);
        check("full_nwr", log_q.size(), 8);
        check("full_last_addr", log_addr(7), 7);
        check("full_done", n_done, 1);
        check("full_wrcnt", wr_count_o, 0);

        // Abort races a pending grant.
        begin_run(0, 0, 0, 4, 0);
        pulse(3'b001, 32'hF0, 0, 0);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        check("abort_idle", busy_o, 0);
        cyc(2);
        check("abort_nwr", log_q.size(), 0);

        // Asynchronous reset in the middle of a strobe.
        begin_run(1, 0, 1, 0, 0);
        pulse(3'b111, 32'h7, 32'h8, 32'h9);
        @(posedge clk);
        #2;
        check("pre_rst_strobe", mem_csb_o != '1, 1);
        rst_n = 1'b0;
        #1;
        check("mrst_csb", mem_csb_o, 2'b11);
        check("mrst_web", mem_web_o, 2'b11);
        check("mrst_busy", busy_o, 0);
        check("mrst_wrcnt", wr_count_o, 0);
        check("mrst_addr", mem_addr_o, 0);
        check("mrst_din", mem_din_o, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // Randomised traffic checked cycle-by-cycle by the model.
        for (int n = 0; n < 3000; n++) begin
            mode   = 1'($urandom);
            sel    = CHW'($urandom_range(0, NCH-1));
            ring   = 1'($urandom);
            count  = (AW+1)'($urandom_range(0, 8));
            tag_en = 1'($urandom);
            start  = ($urandom_range(0, 15) == 0);
            abort  = ($urandom_range(0, 150) == 0);
            if ($urandom_range(0, 31) == 0) ch_en = NCH'($urandom);
            ch_valid = NCH'($urandom & $urandom);
            ch_data  = {$urandom, $urandom, $urandom};
            @(negedge clk);
        end
        start = 1'b0; abort = 1'b0; ch_valid = '0;
        cyc(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_capture_seq.md
Name: adc_capture_seq

Overview:
- Multi-channel capture sequencer between N sinc3 decimator outputs and the banked capture SRAMs.
- Replaces the fixed 3-way channel select with per-channel holding registers, single-channel or round-robin scan capture, and optional channel tagging.
- Adds bounded or ring (ping-pong bank) recording, overrun detection and done signalling.
- Drives the SRAM RW port (csb/web active-low); read-back stays with the Wishbone block.

Parameters:
NCH, 3, number of ADC channels
DW, 32, sample/memory word width
AW, 10, SRAM word address width
NBANK, 2, number of SRAM banks (≥1)
CHW, $clog2(NCH) (min 1), channel index width (derived)

Ports:
wb_clk_i  in  1  system clock
wb_rst_ni  in  1  asynchronous active-low reset
ch_data_i  in  NCH*DW  decimator outputs, channel c at [c*DW +: DW]
ch_valid_i  in  NCH  one-cycle data-valid per channel
ch_en_i  in  NCH  channel enable mask
mode_i  in  1  0 = single (sel_i only), 1 = round-robin scan of enabled channels
sel_i  in  CHW  channel for single mode
ring_i  in  1  0 = stop after one bank, 1 = continuous ping-pong across banks
count_i  in  AW+1  samples per bank; 0 means 2^AW
tag_en_i  in  1  replace data[DW-1 -: CHW] with channel index
start_i  in  1  start pulse
abort_i  in  1  abort pulse
mem_csb_o  out  NBANK  chip select per bank, active-low
mem_web_o  out  NBANK  write enable per bank, active-low
mem_addr_o  out  AW  write address
mem_din_o  out  DW  write data
busy_o  out  1  capture in progress
done_o  out  1  one-cycle pulse at each bank fill
bank_o  out  $clog2(NBANK) (min 1)  bank currently written
wr_count_o  out  AW+1  samples written to current bank
ovr_o  out  NCH  sticky per-channel overrun flags; cleared on start

Behaviour:
- Reset (async on wb_rst_ni low):
  - State IDLE; holds empty.
  - mem_csb_o and mem_web_o all 1; mem_addr_o, mem_din_o, wr_count_o, bank_o = 0.
  - busy_o = 0, done_o = 0, ovr_o = 0.
  - Mid-operation reset: capture is lost, no write strobe survives.
- FSM states IDLE, RUN, DONE.
  - IDLE→RUN on start_i: clears addr, wr_count, bank, holds and ovr_o; latches mode_i, sel_i, ring_i, count_i, tag_en_i.
  - RUN→DONE when the last word of a bank is written and ring_i = 0.
  - DONE→IDLE after one cycle.
  - start_i while busy is ignored.
  - abort_i in RUN/DONE→IDLE at next edge: holds cleared, no further strobes, no done_o.
  - abort_i wins over start_i and over a pending write.
- busy_o = 1 in RUN and DONE.
- Holding registers, one per channel:
  - Edge where ch_valid_i[c] & ch_en_i[c] & RUN: data loaded, full[c] set.
  - Valid arriving on a full, undrained channel: newest overwrites, ovr_o[c] set.
  - Drain and new valid in the same cycle: reload without overrun.
  - Disabled or out-of-mode channels are never loaded.
- Grant, at most one per cycle among full holds:
  - Single mode: only sel_i can be granted.
  - Scan mode: round-robin, search starts at last grant + 1 modulo NCH.
- Write:
  - The granted hold drains; registered outputs at the next edge drive one-cycle strobes mem_csb_o[bank] = mem_web_o[bank] = 0, with mem_addr_o = wr_count and mem_din_o = data (tagged if tag_en).
  - Latency: valid sampled at edge k → strobe visible during the cycle after edge k+1; back-to-back strobes allowed.
  - Other banks stay at 1.
- Counting:
  - wr_count increments per write.
  - When wr_count reaches count_i (0 ⇒ 2^AW): done_o pulses; wr_count → 0.
  - If ring_i: bank_o increments modulo NBANK (with NBANK = 1 the same bank is rewritten).
  - Address never exceeds 2^AW − 1.

Decomposition:
- Shared package adc_capture_pkg:
  - mode encodings MODE_SINGLE/MODE_SCAN
  - FSM state enum
  - NCH/DW/AW defaults
- One sub-module, rr_arbiter, parametrised on NCH: request vector, last-grant pointer → one-hot grant plus index.

Test Plan:
- Single mode, NCH=3, sel=1, count=4: valids on ch1 with data 0xA0..0xA3 → four strobes at bank0 addresses 0..3 with din 0xA0..0xA3; done_o pulses once; busy_o falls; ch0/ch2 valids produce no writes.
- Scan, all enabled, tag_en=1, CHW=2: simultaneous valids ch0/1/2 with 0x0000_0011 → writes on consecutive cycles, order 0, 1, 2; din top bits 00, 01, 10.
- Overrun: ch0 valid on two consecutive cycles while ch1 and ch2 hold grant priority → ovr_o[0] = 1, later write carries second value; start_i clears ovr_o.
- Ring, NBANK=2, count=2: six samples → bank sequence 0,0,1,1,0,0; addresses 0,1,0,1,0,1; done_o ×3; busy_o stays 1.
- count_i=0, AW=3 → done after 8 writes; address wraps 7→0.
- abort_i same cycle as a pending grant → no strobe, state IDLE next cycle. wb_rst_ni low mid-run → csb/web immediately all 1, outputs at reset values.
